// File: rtl/cdc_handshake_tx.sv
// Source-side four-phase req/ack CDC handshake transmitter.
// Optional ack timeout enabled by defining CDC_HS_TIMEOUT_EN.
module cdc_handshake_tx #(
   parameter int NUMSTGS        = 2,
   parameter int DWIDTH         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              src_valid,
   output logic              src_ready,
   input  logic [DWIDTH-1:0] src_data,
   output logic              req_out,
   output logic [DWIDTH-1:0] data_out,
   input  logic              ack_in,
   output logic              busy,
`ifdef CDC_HS_TIMEOUT_EN
   output logic              timeout_err,
`endif
   output logic              tx_done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_HI = 2'd1,
      ACK_LO = 2'd2
   } state_t;

   if (NUMSTGS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("cdc_handshake_tx: NUMSTGS and TIMEOUT_CYCLES must be >= 2");
   end

   state_t              state_q;
   logic [NUMSTGS-1:0]  ack_sync_q;
   logic                ack_s;
   logic                req_q;
   logic [DWIDTH-1:0]   data_q;
   logic                busy_q;
   logic                done_q;

   assign ack_s = ack_sync_q[NUMSTGS-1];

`ifdef CDC_HS_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic          terr_q;
   logic          tmo_q;
   logic          tmo;

   assign tmo         = (cnt_q == TLAST);
   assign timeout_err = terr_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_sync_q <= '0;
      end else begin
         ack_sync_q <= {ack_sync_q[NUMSTGS-2:0], ack_in};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
         cnt_q   <= '0;
         terr_q  <= 1'b0;
         tmo_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
         terr_q <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               if (src_valid) begin
                  data_q  <= src_data;
                  req_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= REQ_HI;
`ifdef CDC_HS_TIMEOUT_EN
                  cnt_q   <= '0;
                  tmo_q   <= 1'b0;
`endif
               end
            end
            REQ_HI: begin
               if (ack_s) begin
                  req_q   <= 1'b0;
                  state_q <= ACK_LO;
`ifdef CDC_HS_TIMEOUT_EN
                  cnt_q   <= '0;
               end else if (tmo) begin
                  // no ack at all: abandon, but still wait out ACK_LO
                  req_q   <= 1'b0;
                  state_q <= ACK_LO;
                  cnt_q   <= '0;
                  terr_q  <= 1'b1;
                  tmo_q   <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
`endif
               end
            end
            ACK_LO: begin
               if (!ack_s) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
`ifdef CDC_HS_TIMEOUT_EN
                  done_q  <= ~tmo_q;
                  cnt_q   <= '0;
               end else if (tmo) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  terr_q  <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
`else
                  done_q  <= 1'b1;
`endif
               end
            end
            default: begin
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign src_ready = (state_q == IDLE);
   assign req_out   = req_q;
   assign data_out  = data_q;
   assign busy      = busy_q;
   assign tx_done   = done_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx with a data scoreboard.
// Timeout scenario runs only when CDC_HS_TIMEOUT_EN is defined.
module tb_cdc_handshake_tx;

   localparam int NS = 2;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          src_valid;
   logic          src_ready;
   logic [DW-1:0] src_data;
   logic          req_out;
   logic [DW-1:0] data_out;
   logic          ack_in;
   logic          busy;
   logic          tx_done;
`ifdef CDC_HS_TIMEOUT_EN
   logic          timeout_err;
`endif

   int n_chk = 0;
   int n_err = 0;
   int n_done = 0;
   logic req_prev = 1'b0;
   logic [DW-1:0] sb_q[$];

   cdc_handshake_tx #(
      .NUMSTGS(NS),
      .DWIDTH(DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .src_valid(src_valid),
      .src_ready(src_ready),
      .src_data(src_data),
      .req_out(req_out),
      .data_out(data_out),
      .ack_in(ack_in),
      .busy(busy),
`ifdef CDC_HS_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: each req rise must present the next accepted word
   always @(negedge clk) begin
      if (!reset) begin
         if (req_out && !req_prev) begin
            if (sb_q.size() == 0) chk("sb_empty", 1, 0);
            else chk("sb_data", data_out, sb_q.pop_front());
         end
         if (tx_done) n_done++;
      end
      req_prev <= req_out;
   end

   initial begin
      int cyc;
      int idx;
      int nd;
      logic acc;
      logic [DW-1:0] words [2];
      words[0] = 32'h1;
      words[1] = 32'h2;

      reset = 1'b1; src_valid = 1'b0; src_data = '0; ack_in = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_req", req_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_ready", src_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", tx_done, 0);
      tick();
      chk("idle_ready", src_ready, 1);

      // basic transfer
      src_valid = 1'b1; src_data = 32'hDEADBEEF;
      sb_q.push_back(32'hDEADBEEF);
      tick();
      src_valid = 1'b0; src_data = 32'h0;
      chk("c1_req", req_out, 1);
      chk("c1_data", data_out, 32'hDEADBEEF);
      chk("c1_ready", src_ready, 0);
      chk("c1_busy", busy, 1);
      tick(); tick();
      ack_in = 1'b1;
      chk("c3_req", req_out, 1);
      tick(); tick();
      chk("c5_req", req_out, 1);
      tick();
      chk("c6_req", req_out, 0);
      chk("c6_data", data_out, 32'hDEADBEEF);
      tick(); tick();
      ack_in = 1'b0;
      tick(); tick();
      chk("c10_done", tx_done, 0);
      chk("c10_busy", busy, 1);
      tick();
      chk("c11_done", tx_done, 1);
      chk("c11_ready", src_ready, 1);
      chk("c11_busy", busy, 0);
      chk("c11_data", data_out, 32'hDEADBEEF);
      tick();
      chk("c12_done", tx_done, 0);

      // back-to-back words with a responder echoing req
      idx = 0; acc = 1'b0; nd = 0;
      src_valid = 1'b1; src_data = words[0];
      for (cyc = 0; cyc < 80 && nd < 2; cyc++) begin
         if (acc) begin
            idx++;
            acc = 1'b0;
            src_valid = (idx < 2);
            src_data = (idx < 2) ? words[idx] : '0;
         end
         ack_in = req_out;
         if (tx_done) nd++;
         if (src_valid && src_ready) begin
            sb_q.push_back(src_data);
            if (idx > 0) chk("b2b_acc_in_done", tx_done, 1);
            acc = 1'b1;
         end
         tick();
      end
      chk("b2b_done_cnt", nd, 2);
      chk("b2b_accepts", idx, 2);
      ack_in = 1'b0;
      tick(); tick(); tick();
      chk("b2b_sb_empty", sb_q.size(), 0);
      chk("b2b_idle", busy, 0);

      // reset in REQ_HI
      src_valid = 1'b1; src_data = 32'hA5A5A5A5;
      sb_q.push_back(32'hA5A5A5A5);
      tick();
      src_valid = 1'b0;
      tick();
      chk("r_mid_req", req_out, 1);
      chk("r_mid_data", data_out, 32'hA5A5A5A5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("r_req", req_out, 0);
      chk("r_data", data_out, 0);
      chk("r_busy", busy, 0);
      chk("r_ready", src_ready, 1);
      chk("r_done", tx_done, 0);

      // stale ack held high; glitches in IDLE are ignored
      ack_in = 1'b1;
      tick(); tick(); tick();
      chk("st_idle_busy", busy, 0);
      chk("st_idle_req", req_out, 0);
      src_valid = 1'b1; src_data = 32'h55AA55AA;
      sb_q.push_back(32'h55AA55AA);
      tick();
      src_valid = 1'b0;
      for (cyc = 0; cyc < 10 && req_out; cyc++) tick();
      chk("st_req_fell", req_out, 0);
      chk("st_req_quick", (cyc <= NS + 1), 1);
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         if (tx_done) nd++;
         tick();
      end
      chk("st_stall_done", nd, 0);
      chk("st_stall_busy", busy, 1);
      chk("st_stall_ready", src_ready, 0);
      ack_in = 1'b0;
      for (cyc = 0; cyc < 10 && !tx_done; cyc++) tick();
      chk("st_done", tx_done, 1);
      chk("st_done_lat", (cyc <= NS + 2), 1);
      tick();

`ifdef CDC_HS_TIMEOUT_EN
      // no ack ever: timeout in REQ_HI, then return to IDLE
      ack_in = 1'b0;
      src_valid = 1'b1; src_data = 32'h77;
      sb_q.push_back(32'h77);
      tick();
      src_valid = 1'b0;
      nd = 0;
      for (cyc = 0; cyc < 40 && req_out; cyc++) begin
         if (timeout_err) nd++;
         tick();
      end
      chk("to_req_width", cyc, TO);
      chk("to_err_early", nd, 0);
      chk("to_err", timeout_err, 1);
      chk("to_done0", tx_done, 0);
      tick();
      chk("to_err_pulse", timeout_err, 0);
      chk("to_idle", busy, 0);
      chk("to_ready", src_ready, 1);
      chk("to_done1", tx_done, 0);
      tick();
`endif

      tick(); tick();
      chk("total_done", n_done, 4);
      chk("sb_final", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
